// File: rtl/dmem_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : dmem_io_bus
// Purpose  : Data-side memory and memory-mapped I/O for the single-cycle
//            processor: word RAM, LED register, synchronized switches,
//            prescaled compare timer and a serial transmitter.
//            Reads are combinational; all writes land on the CLK rising edge.
// Ports    : CLK, RESET (sync, active-high)
//            ADDR/WDATA/MW  - processor address, store data, write enable
//            RDATA          - combinational read data back to processor
//            SW / LED       - switch inputs / LED register
//            TX             - serial output, idle high
//            TIMER_IRQ      - registered timer match flag
// Revision : 1.0 - initial release
// ============================================================================
module dmem_io_bus #(
  parameter int RAM_AW       = 8,
  parameter int PRESCALE     = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic        MW,
  output logic [15:0] RDATA,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        TX,
  output logic        TIMER_IRQ
);

  localparam int c_RAM_DEPTH = 1 << RAM_AW;
  localparam int c_PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);
  localparam logic [c_BAUD_W-1:0]  c_BAUD_MAX  = c_BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [15:0] c_A_LED    = 16'hFF00;
  localparam logic [15:0] c_A_SW     = 16'hFF01;
  localparam logic [15:0] c_A_COUNT  = 16'hFF02;
  localparam logic [15:0] c_A_CMP    = 16'hFF03;
  localparam logic [15:0] c_A_TSTAT  = 16'hFF04;
  localparam logic [15:0] c_A_TXDATA = 16'hFF05;
  localparam logic [15:0] c_A_TXSTAT = 16'hFF06;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  logic [15:0]          r_mem [0:c_RAM_DEPTH-1];
  logic [15:0]          r_led, r_sw_meta, r_sw_sync, r_compare, r_count;
  logic [c_PRESC_W-1:0] r_presc;
  logic                 r_flag;
  logic [1:0]           r_state, w_state_nxt;
  logic [c_BAUD_W-1:0]  r_baud;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;

  logic w_wr, w_ram_sel, w_tick, w_match, w_cnt_clr, w_flag_set, w_flag_clr;
  logic w_tx_start, w_baud_done, w_busy;

  // Reset takes priority over any store issued in the same cycle.
  assign w_wr      = MW & ~RESET;
  // Shift in a 32-bit context so RAM_AW up to 16 stays legal.
  assign w_ram_sel = (({16'd0, ADDR} >> RAM_AW) == 32'd0);

  // --------------------------------------------------------------------------
  // Data RAM (not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_wr && w_ram_sel) r_mem[ADDR[RAM_AW-1:0]] <= WDATA;
  end

  // --------------------------------------------------------------------------
  // LED, compare register and switch synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_led     <= '0;
      r_compare <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
      if (w_wr && ADDR == c_A_LED) r_led     <= WDATA;
      if (w_wr && ADDR == c_A_CMP) r_compare <= WDATA;
    end
  end

  // --------------------------------------------------------------------------
  // Timer: a COUNT write suppresses the tick entirely; a flag set beats a clear.
  // --------------------------------------------------------------------------
  assign w_tick     = (r_presc == c_PRESC_MAX);
  assign w_match    = (r_compare != 16'd0) && (r_count == r_compare - 16'd1);
  assign w_cnt_clr  = w_wr && (ADDR == c_A_COUNT);
  assign w_flag_clr = w_wr && (ADDR == c_A_TSTAT) && WDATA[0];
  assign w_flag_set = w_tick && w_match && !w_cnt_clr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc <= '0;
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_presc <= '0;
        r_count <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_count <= w_match ? 16'd0 : r_count + 16'd1;
      end
      if (w_flag_set)      r_flag <= 1'b1;
      else if (w_flag_clr) r_flag <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Serial transmitter
  // --------------------------------------------------------------------------
  assign w_tx_start  = w_wr && (ADDR == c_A_TXDATA) && (r_state == c_ST_IDLE);
  assign w_baud_done = (r_baud == c_BAUD_MAX);

  // State register plus the bit-timing datapath that moves with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= c_ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        if (w_tx_start) r_shift <= WDATA[7:0];
      end else begin
        r_baud <= w_baud_done ? '0 : r_baud + 1'b1;
        if (r_state == c_ST_DATA && w_baud_done) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_tx_start)                     w_state_nxt = c_ST_START;
      c_ST_START: if (w_baud_done)                    w_state_nxt = c_ST_DATA;
      c_ST_DATA:  if (w_baud_done && r_bit == 3'd7)   w_state_nxt = c_ST_STOP;
      c_ST_STOP:  if (w_baud_done)                    w_state_nxt = c_ST_IDLE;
      default:                                        w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    TX     = 1'b1;
    w_busy = (r_state != c_ST_IDLE);
    case (r_state)
      c_ST_START: TX = 1'b0;
      c_ST_DATA:  TX = r_shift[0];
      default:    TX = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    RDATA = '0;
    if (w_ram_sel) begin
      RDATA = r_mem[ADDR[RAM_AW-1:0]];
    end else begin
      case (ADDR)
        c_A_LED:    RDATA = r_led;
        c_A_SW:     RDATA = r_sw_sync;
        c_A_COUNT:  RDATA = r_count;
        c_A_CMP:    RDATA = r_compare;
        c_A_TSTAT:  RDATA = {15'd0, r_flag};
        c_A_TXSTAT: RDATA = {15'd0, w_busy};
        default:    RDATA = '0;
      endcase
    end
  end

  assign LED       = r_led;
  assign TIMER_IRQ = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_dmem_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_io_bus
// Purpose  : Self-checking bench for dmem_io_bus: vector table for the
//            address map, directed sequences for timer, serial frame,
//            reset behaviour and switch synchronizer latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_io_bus;

  logic        CLK = 1'b0;
  logic        RESET, MW, TX, TIMER_IRQ;
  logic [15:0] ADDR, WDATA, SW, RDATA, LED;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];

  dmem_io_bus #(
    .RAM_AW      (8),
    .PRESCALE    (4),
    .CLKS_PER_BIT(16)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .MW       (MW),
    .RDATA    (RDATA),
    .SW       (SW),
    .LED      (LED),
    .TX       (TX),
    .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents a store at the current negedge; the following posedge commits it.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; WDATA = d; MW = 1'b1;
    @(negedge CLK);
    MW = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    ADDR = a; MW = 1'b0;
    #1 chk(name, RDATA, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  txb;
    logic [15:0] exp_cnt;
    int          j;

    vecs[0]  = '{1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h00FF, 16'hBEEF, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    vecs[3]  = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'hBEEF};
    vecs[4]  = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 16'hFF00, 16'hA5A5, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 16'hFF00, 16'h0000, 1'b1, 16'hA5A5};
    vecs[7]  = '{1'b1, 16'hFF03, 16'h0007, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0007};
    vecs[9]  = '{1'b0, 16'hFF05, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 16'hFF06, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 16'hFF07, 16'h0000, 1'b1, 16'h0000};
    vecs[12] = '{1'b1, 16'hFF07, 16'hFFFF, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 16'hFF00, 16'h0000, 1'b1, 16'hA5A5};
    vecs[14] = '{1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0007};
    vecs[15] = '{1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h0000};

    RESET = 1'b1; MW = 1'b0; ADDR = '0; WDATA = '0; SW = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_led", LED, 16'h0000);
    chk("rst_tx", {15'd0, TX}, 16'h0001);
    chk("rst_irq", {15'd0, TIMER_IRQ}, 16'h0000);
    RESET = 1'b0;
    rd("rst_count", 16'hFF02, 16'h0000);
    rd("rst_busy", 16'hFF06, 16'h0000);
    @(negedge CLK);

    // Address map vectors
    for (int i = 0; i < 16; i++) begin
      ADDR = vecs[i].addr; WDATA = vecs[i].wdata; MW = vecs[i].we;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d", i), RDATA, vecs[i].exp);
      @(negedge CLK);
    end
    MW = 1'b0;
    #1 chk("led_pin", LED, 16'hA5A5);

    // Reset with a colliding store
    ADDR = 16'hFF00; WDATA = 16'hFFFF; MW = 1'b1; RESET = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst2_led", LED, 16'h0000);
    chk("rst2_tx", {15'd0, TX}, 16'h0001);
    chk("rst2_irq", {15'd0, TIMER_IRQ}, 16'h0000);
    RESET = 1'b0; MW = 1'b0;
    rd("rst2_ram", 16'h0005, 16'h1234);

    // Timer: COMPARE=3, then clear count; flag expected 12 cycles later
    do_write(16'hFF03, 16'h0003);
    do_write(16'hFF02, 16'h0000);
    ADDR = 16'hFF02;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      #1;
      exp_cnt = (k < 4) ? 16'd0 : (k < 8) ? 16'd1 : (k < 12) ? 16'd2 : 16'd0;
      chk($sformatf("tmr_count_k%0d", k), RDATA, exp_cnt);
      chk($sformatf("tmr_irq_k%0d", k), {15'd0, TIMER_IRQ}, (k == 12) ? 16'd1 : 16'd0);
    end
    do_write(16'hFF04, 16'h0001);
    #1 chk("tmr_clear", {15'd0, TIMER_IRQ}, 16'h0000);
    repeat (10) @(negedge CLK);
    do_write(16'hFF04, 16'h0001);       // lands on the next match edge
    #1 chk("tmr_set_wins", {15'd0, TIMER_IRQ}, 16'h0001);
    rd("tmr_tstat", 16'hFF04, 16'h0001);
    rd("tmr_count_wrap", 16'hFF02, 16'h0000);

    // Full frame of 0xA5, plus an ignored write while busy
    txb = 8'hA5;
    do_write(16'hFF05, 16'h00A5);
    for (int jj = 0; jj < 180; jj++) begin
      if (jj == 20) begin
        ADDR = 16'hFF05; WDATA = 16'h00FF; MW = 1'b1;
      end else begin
        ADDR = 16'hFF06; MW = 1'b0;
      end
      #1;
      if (jj < 16)       chk($sformatf("tx_start_j%0d", jj), {15'd0, TX}, 16'd0);
      else if (jj < 144) chk($sformatf("tx_data_j%0d", jj), {15'd0, TX}, {15'd0, txb[(jj-16)/16]});
      else               chk($sformatf("tx_stop_j%0d", jj), {15'd0, TX}, 16'd1);
      if (jj == 20) chk("txdata_reads0", RDATA, 16'h0000);
      else          chk($sformatf("tx_busy_j%0d", jj), RDATA, (jj < 160) ? 16'd1 : 16'd0);
      @(negedge CLK);
    end
    MW = 1'b0;

    // Reset in the middle of a frame
    do_write(16'hFF05, 16'h005A);
    repeat (49) @(negedge CLK);
    #1 chk("mid_tx_running", {15'd0, TX}, 16'h0000);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("mid_rst_tx", {15'd0, TX}, 16'h0001);
    rd("mid_rst_busy", 16'hFF06, 16'h0000);
    do_write(16'hFF05, 16'h003C);
    #1 chk("tx2_start", {15'd0, TX}, 16'h0000);
    rd("tx2_busy", 16'hFF06, 16'h0001);
    repeat (24) @(negedge CLK);
    #1 chk("tx2_bit0", {15'd0, TX}, 16'h0000);
    repeat (32) @(negedge CLK);
    #1 chk("tx2_bit2", {15'd0, TX}, 16'h0001);
    ADDR = 16'hFF06;
    j = 56;
    while (RDATA[0] && j < 300) begin
      @(negedge CLK);
      #1;
      j++;
    end
    chk("tx2_frame_len", 16'(j), 16'd160);

    // Switch synchronizer latency
    SW = 16'h00F0; ADDR = 16'hFF01;
    #1 chk("sw_lat0", RDATA, 16'h0000);
    @(negedge CLK);
    #1 chk("sw_lat1", RDATA, 16'h0000);
    @(negedge CLK);
    #1 chk("sw_lat2", RDATA, 16'h00F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_io_bus.md
Name: dmem_io_bus

Overview:
Data-side memory and memory-mapped I/O block that sits directly downstream of the single-cycle processor. It consumes the processor's address, write-data and write-enable outputs, and returns read data on the processor's data-in port.
- Contains a word-addressed data RAM, an LED output register, synchronized switch inputs, a prescaled compare timer and a UART-style serial transmitter.
- Read data is combinational so the processor completes a load in one cycle; all writes take effect on the CLK rising edge.

Parameters:
RAM_AW, 8, RAM address width; RAM occupies 0x0000..(2^RAM_AW - 1).
PRESCALE, 4, CLK cycles per timer tick (>=1).
CLKS_PER_BIT, 16, CLK cycles per serial bit (>=2).

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
ADDR  input  16  word address from processor (Adrout)
WDATA  input  16  store data from processor (Dout)
MW  input  1  memory write enable, sampled at CLK edge
RDATA  output  16  combinational read data to processor (Din)
SW  input  16  asynchronous switch inputs
LED  output  16  LED register
TX  output  1  serial out, idle high
TIMER_IRQ  output  1  copy of timer match flag

Behaviour:
- Reset (RESET=1 at edge): LED=0, timer count=0, compare=0, prescaler=0, match flag=0, TX FSM to IDLE, TX=1, switch synchronizer=0. RAM contents unaffected. RESET overrides MW in the same cycle.
- Address map (reads combinational, 0 cycles latency; writes on edge when MW=1):
  - 0x0000..RAM top: RAM. Read returns mem[ADDR]; write stores WDATA.
  - 0xFF00 LED: RW.
  - 0xFF01 SW: RO; returns 2-flop synchronized SW (2-cycle latency from pin).
  - 0xFF02 COUNT: RO; write of any value clears count and prescaler.
  - 0xFF03 COMPARE: RW.
  - 0xFF04 TSTAT: bit0 = match flag; write with WDATA[0]=1 clears the flag.
  - 0xFF05 TXDATA: write loads WDATA[7:0] and starts transmit if idle; ignored if busy. Reads 0.
  - 0xFF06 TXSTAT: bit0 = busy.
  - All other addresses: read 0, write ignored. Unused register bits read 0.
- Timer:
  - Prescaler counts 0..PRESCALE-1; a tick occurs when it wraps.
  - On each tick, if COMPARE!=0 and count==COMPARE-1, then count<=0 and the flag is set; otherwise count<=count+1 (16-bit wrap 0xFFFF->0).
  - COMPARE=0 means free-run with no flag.
- Timer simultaneous events:
  - COUNT write in a tick cycle: the write wins (count=0, prescaler=0).
  - Flag clear and flag set in the same cycle: set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1, busy=0.
  - Accepted write: START for CLKS_PER_BIT cycles (TX=0), then DATA for 8 bits LSB first, each CLKS_PER_BIT cycles, then STOP for CLKS_PER_BIT cycles (TX=1), then IDLE.
  - Busy=1 from the edge after the accepting write until the return to IDLE. Total frame = 10*CLKS_PER_BIT cycles.
  - The next write is accepted in the first IDLE cycle.
  - RESET mid-frame aborts the frame: TX=1 on the next edge.
- TIMER_IRQ = match flag (registered, no combinational path from inputs).

Test Plan:
1. RAM: write 0x1234 to 0x0005, 0xBEEF to 0x00FF, then read both -> RDATA 0x1234/0xBEEF in the same cycle as ADDR. Read 0x0100 -> 0x0000.
2. Reset: drive RESET with MW=1, ADDR=0xFF00, WDATA=0xFFFF -> LED stays 0, TX=1, TIMER_IRQ=0. RAM 0x0005 still 0x1234.
3. Timer: PRESCALE=4, COMPARE=3, after clearing COUNT -> flag set 12 cycles after the clear. Count sequence 0,1,2,0. Write TSTAT=1 -> flag 0. Clear and match in the same cycle -> flag remains 1.
4. TX: CLKS_PER_BIT=16, write 0xFF05=0x00A5 -> TX low 16 cycles, then bits 1,0,1,0,0,1,0,1, then high. Busy=1 for 160 cycles. A second write during busy produces no second frame.
5. Reset mid-frame: RESET at cycle 50 of a frame -> TX=1 and busy=0 after that edge. A new write is then accepted normally.
6. Switches/unmapped: SW=0x00F0 -> reads 0x00F0 from 0xFF01 two cycles later. Read 0xFF07 -> 0. Write 0xFF07 -> no register changes.
